// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the universal shift register.
//   usr_mode_t - 2-bit operation select carried on the mode port
//   MODE_*     - encodings of hold / shift-up / shift-down / parallel load
package usr_pkg;

  typedef logic [1:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD = 2'b00;
  localparam usr_mode_t MODE_UP   = 2'b01;
  localparam usr_mode_t MODE_DN   = 2'b10;
  localparam usr_mode_t MODE_LOAD = 2'b11;

endpackage : usr_pkg

// File: rtl/usr_fill_cnt.sv
// usr_fill_cnt: saturating fill counter for the shift register.
//   clk, n_rst - clock, async active-low reset
//   clr        - synchronous clear to 0 (highest priority)
//   load       - jump straight to MAX
//   inc        - count up by one, holding at MAX
//   cnt        - current count
//   full       - cnt == MAX
module usr_fill_cnt #(
  parameter int MAX   = 4,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_MAX;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign full = (cnt == CNT_MAX);

endmodule : usr_fill_cnt

// File: rtl/univ_shift_register.sv
// univ_shift_register: parametrised multi-bit, multi-stage shift register.
//   clk, n_rst  - clock, async active-low reset
//   en          - operation enable (clr acts regardless)
//   clr         - synchronous clear of stages and fill count
//   mode        - hold / shift-up / shift-down / parallel load
//   rot         - in shift modes, recirculate the end stage instead of ser_in
//   ser_in      - serial data into the pipe
//   par_in      - parallel load data, stage k at [k*WIDTH +: WIDTH]
//   par_out     - all stages, same packing as par_in
//   ser_out_up  - stage DEPTH-1 (exit of shift-up)
//   ser_out_dn  - stage 0 (exit of shift-down)
//   fill_cnt    - stages holding fresh data since last clr/load
//   full        - fill_cnt == DEPTH
module univ_shift_register
  import usr_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   en,
  input  logic                   clr,
  input  usr_mode_t              mode,
  input  logic                   rot,
  input  logic [WIDTH-1:0]       ser_in,
  input  logic [DEPTH*WIDTH-1:0] par_in,
  output logic [DEPTH*WIDTH-1:0] par_out,
  output logic [WIDTH-1:0]       ser_out_up,
  output logic [WIDTH-1:0]       ser_out_dn,
  output logic [CNT_W-1:0]       fill_cnt,
  output logic                   full
);

  logic [WIDTH-1:0] stage [DEPTH];
  logic             do_op;
  logic             do_shift;
  logic             do_load;
  logic             do_inc;

  assign do_op    = en && !clr;
  assign do_shift = do_op && ((mode == MODE_UP) || (mode == MODE_DN));
  assign do_load  = do_op && (mode == MODE_LOAD);
  // A rotate only recirculates existing data, so it adds nothing fresh.
  assign do_inc   = do_shift && !rot;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] up_src;
    logic [WIDTH-1:0] dn_src;

    if (k == 0) begin : g_up_head
      assign up_src = rot ? stage[DEPTH-1] : ser_in;
    end else begin : g_up_body
      assign up_src = stage[k-1];
    end

    if (k == DEPTH - 1) begin : g_dn_head
      assign dn_src = rot ? stage[0] : ser_in;
    end else begin : g_dn_body
      assign dn_src = stage[k+1];
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        q <= '0;
      end else if (clr) begin
        q <= '0;
      end else if (en) begin
        case (mode)
          MODE_UP:   q <= up_src;
          MODE_DN:   q <= dn_src;
          MODE_LOAD: q <= par_in[k*WIDTH +: WIDTH];
          default:   q <= q;
        endcase
      end
    end

    assign stage[k]                   = q;
    assign par_out[k*WIDTH +: WIDTH]  = q;
  end

  assign ser_out_up = stage[DEPTH-1];
  assign ser_out_dn = stage[0];

  usr_fill_cnt #(
    .MAX   (DEPTH),
    .CNT_W (CNT_W)
  ) u_fill_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (clr),
    .load  (do_load),
    .inc   (do_inc),
    .cnt   (fill_cnt),
    .full  (full)
  );

endmodule : univ_shift_register

// File: tb/tb_univ_shift_register.sv
// tb_univ_shift_register: directed bench with two instances,
// a 1-bit x 4 legacy-equivalent one and an 8-bit x 4 one.
module tb_univ_shift_register;
  import usr_pkg::*;

  logic clk;
  logic n_rst;

  // 1-bit x 4 instance
  logic        a_en, a_clr, a_rot;
  usr_mode_t   a_mode;
  logic [0:0]  a_ser_in;
  logic [3:0]  a_par_in, a_par_out;
  logic [0:0]  a_ser_out_up, a_ser_out_dn;
  logic [2:0]  a_fill_cnt;
  logic        a_full;

  // 8-bit x 4 instance
  logic        b_en, b_clr, b_rot;
  usr_mode_t   b_mode;
  logic [7:0]  b_ser_in;
  logic [31:0] b_par_in, b_par_out;
  logic [7:0]  b_ser_out_up, b_ser_out_dn;
  logic [2:0]  b_fill_cnt;
  logic        b_full;

  int n_cmp = 0;
  int n_err = 0;

  univ_shift_register #(.WIDTH(1), .DEPTH(4)) u_dut_a (
    .clk(clk), .n_rst(n_rst), .en(a_en), .clr(a_clr), .mode(a_mode), .rot(a_rot),
    .ser_in(a_ser_in), .par_in(a_par_in), .par_out(a_par_out),
    .ser_out_up(a_ser_out_up), .ser_out_dn(a_ser_out_dn),
    .fill_cnt(a_fill_cnt), .full(a_full)
  );

  univ_shift_register #(.WIDTH(8), .DEPTH(4)) u_dut_b (
    .clk(clk), .n_rst(n_rst), .en(b_en), .clr(b_clr), .mode(b_mode), .rot(b_rot),
    .ser_in(b_ser_in), .par_in(b_par_in), .par_out(b_par_out),
    .ser_out_up(b_ser_out_up), .ser_out_dn(b_ser_out_dn),
    .fill_cnt(b_fill_cnt), .full(b_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Legacy-compatible serial pattern and expected stage3..0 after each edge.
  logic [0:0] seq_in  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] seq_exp [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};

  initial begin
    n_rst    = 1'b0;
    a_en = 1'b0; a_clr = 1'b0; a_rot = 1'b0; a_mode = MODE_HOLD; a_ser_in = '0; a_par_in = '0;
    b_en = 1'b0; b_clr = 1'b0; b_rot = 1'b0; b_mode = MODE_HOLD; b_ser_in = '0; b_par_in = '0;
    repeat (2) tick();

    chk("rst_par_a",  64'(a_par_out),  64'h0);
    chk("rst_cnt_a",  64'(a_fill_cnt), 64'h0);
    chk("rst_full_a", 64'(a_full),     64'h0);
    chk("rst_par_b",  64'(b_par_out),  64'h0);
    n_rst = 1'b1;

    // 1: legacy shift-up, W=1
    a_en = 1'b1; a_mode = MODE_UP; a_rot = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_ser_in = seq_in[i];
      tick();
      chk($sformatf("up_par_%0d", i), 64'(a_par_out),  64'(seq_exp[i]));
      chk($sformatf("up_cnt_%0d", i), 64'(a_fill_cnt), 64'(i + 1));
      chk($sformatf("up_full_%0d", i), 64'(a_full),    64'(i == 3));
    end
    chk("up_ser_out", 64'(a_ser_out_up), 64'h1);
    a_ser_in = 1'b0;
    tick();
    chk("up_sat_par",  64'(a_par_out),  64'b0110);
    chk("up_sat_cnt",  64'(a_fill_cnt), 64'd4);
    chk("up_sat_full", 64'(a_full),     64'h1);
    a_mode = MODE_HOLD;
    tick();
    chk("hold_par_a", 64'(a_par_out), 64'b0110);
    a_en = 1'b0;

    // 2: parallel load then rotate-down, W=8
    b_en = 1'b1; b_mode = MODE_LOAD; b_par_in = 32'hDDCC_BBAA;
    tick();
    chk("ld_par",   64'(b_par_out),    64'hDDCC_BBAA);
    chk("ld_s0",    64'(b_ser_out_dn), 64'hAA);
    chk("ld_s3",    64'(b_ser_out_up), 64'hDD);
    chk("ld_cnt",   64'(b_fill_cnt),   64'd4);
    b_mode = MODE_DN; b_rot = 1'b1; b_par_in = '0;
    tick();
    chk("rdn_par",  64'(b_par_out),    64'hAADD_CCBB);
    chk("rdn_sdn",  64'(b_ser_out_dn), 64'hBB);
    chk("rdn_cnt",  64'(b_fill_cnt),   64'd4);

    // 3: rotate-up undoes it; four more rotates are the identity
    b_mode = MODE_UP;
    tick();
    chk("rup_par",  64'(b_par_out),    64'hDDCC_BBAA);
    repeat (4) tick();
    chk("rup4_par", 64'(b_par_out),    64'hDDCC_BBAA);
    chk("rup4_cnt", 64'(b_fill_cnt),   64'd4);

    // 4: priority clr > en > mode
    b_en = 1'b0; b_mode = MODE_UP; b_rot = 1'b0; b_ser_in = 8'h11;
    tick();
    chk("en0_par",  64'(b_par_out),    64'hDDCC_BBAA);
    chk("en0_cnt",  64'(b_fill_cnt),   64'd4);
    b_clr = 1'b1; b_mode = MODE_LOAD; b_par_in = 32'hFFFF_FFFF;
    tick();
    chk("clr_par",  64'(b_par_out),    64'h0);
    chk("clr_cnt",  64'(b_fill_cnt),   64'd0);
    chk("clr_full", 64'(b_full),       64'h0);
    b_clr = 1'b0;

    // 5: async reset between edges
    b_en = 1'b1; b_mode = MODE_LOAD; b_par_in = 32'h1234_5678;
    tick();
    chk("ld2_par",  64'(b_par_out),    64'h1234_5678);
    b_mode = MODE_HOLD;
    #2 n_rst = 1'b0;
    #1;
    chk("arst_par", 64'(b_par_out),    64'h0);
    chk("arst_cnt", 64'(b_fill_cnt),   64'd0);
    #1 n_rst = 1'b1;
    b_mode = MODE_UP; b_rot = 1'b0; b_ser_in = 8'hFF;
    tick();
    chk("post_par", 64'(b_par_out),    64'h0000_00FF);
    chk("post_cnt", 64'(b_fill_cnt),   64'd1);

    // 6: shift-down fill
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0; b_mode = MODE_DN; b_rot = 1'b0;
    b_ser_in = 8'h0A; tick();
    b_ser_in = 8'h0B; tick();
    b_ser_in = 8'h0C; tick();
    chk("dn_par",   64'(b_par_out),    64'h0C0B_0A00);
    chk("dn_cnt",   64'(b_fill_cnt),   64'd3);
    chk("dn_full",  64'(b_full),       64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_univ_shift_register
